// File: rtl/cca_sweep_ctl_pkg.sv
// Purpose: shared types and defaults for the cache sweep controller and its entry counter.
// Latency: n/a (types, constants and helper functions only).
// Backpressure: n/a.
//
// Contents: sweep function and FSM state enums, default geometry, address-width helper.
// Optional feature macro used by the controller: CCA_PAGE_SWEEP_EN.
package cca_sweep_ctl_pkg;

    localparam int unsigned NSETS_DEF  = 128;
    localparam int unsigned NWAYS_DEF  = 4;
    localparam int unsigned PAGE_W_DEF = 13;
    localparam int unsigned ADDR_W_DEF = $clog2(NSETS_DEF) + $clog2(NWAYS_DEF);

    // Sweep function as latched by the controller; the raw 2'b11 code folds to VALIDATE.
    typedef enum logic [1:0] {
        FUNC_CLEAR    = 2'b00,
        FUNC_VALIDATE = 2'b01,
        FUNC_UNLOAD   = 2'b10
    } sweep_func_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_CHK  = 3'd2,
        ST_WB   = 3'd3,
        ST_WR   = 3'd4,
        ST_DONE = 3'd5
    } sweep_state_e;

    function automatic sweep_func_e decode_func(input logic [1:0] raw);
        case (raw)
            2'b00:   return FUNC_CLEAR;
            2'b10:   return FUNC_UNLOAD;
            default: return FUNC_VALIDATE;
        endcase
    endfunction

    // Entry address is {set, way}, so its width is the sum of both index widths.
    function automatic int unsigned entry_addr_w(input int unsigned nsets, input int unsigned nways);
        return $clog2(nsets) + $clog2(nways);
    endfunction

endpackage

// File: rtl/cca_sweep_ctr.sv
// Purpose: directory entry counter for the sweep, {set, way} order with way fastest.
// Latency: count updates one clk after clr/inc; last is combinational from the count.
// Backpressure: none; the controller only pulses inc when it moves to the next entry.
//
// Ports: clk, RESET_N (sync, active-low), clr, inc, cnt (current entry), last (cnt is final entry).
module cca_sweep_ctr #(
    parameter int unsigned NENT   = 512,
    parameter int unsigned ADDR_W = 9
) (
    input  logic              clk,
    input  logic              RESET_N,
    input  logic              clr,
    input  logic              inc,
    output logic [ADDR_W-1:0] cnt,
    output logic              last
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NENT - 1);

    logic [ADDR_W-1:0] cnt_d;
    logic [ADDR_W-1:0] cnt_q;

    // A plain binary increment walks ways first because the way index sits in the low bits.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = cnt_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!RESET_N) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    assign last = (cnt_q == LAST_IDX);

endmodule

// File: rtl/cca_sweep_ctl.sv
// Purpose: sequences cache clear / validate / unload sweeps over every directory entry.
// Latency: 2 clk per skipped entry, 3 per rewritten entry, plus writeback handshake time.
// Backpressure: ebox_hold stalls only the read step; wb_req is held until wb_ack.
//
// Ports: clk, RESET_N (sync, active-low); start/func request; ebox_hold pause;
//        dir_rd/dir_adr read with dir_valid/dir_dirty returned next cycle;
//        wb_req/wb_ack writeback handshake; dir_wr/dir_wr_valid/dir_wr_dirty rewrite;
//        SWEEP_BUSY level and SWEEP_DONE pulse to the APR.
// Optional: CCA_PAGE_SWEEP_EN adds page_sweep/page_sel (sampled with start) and dir_page,
//        restricting the sweep to entries whose tag page matches page_sel.
module cca_sweep_ctl
    import cca_sweep_ctl_pkg::*;
#(
    parameter int unsigned NSETS  = NSETS_DEF,
    parameter int unsigned NWAYS  = NWAYS_DEF,
    parameter int unsigned PAGE_W = PAGE_W_DEF,
    localparam int unsigned ADDR_W = entry_addr_w(NSETS, NWAYS)
) (
    input  logic              clk,
    input  logic              RESET_N,
    input  logic              start,
    input  logic [1:0]        func,
`ifdef CCA_PAGE_SWEEP_EN
    input  logic              page_sweep,
    input  logic [PAGE_W-1:0] page_sel,
    input  logic [PAGE_W-1:0] dir_page,
`endif
    input  logic              ebox_hold,
    output logic              dir_rd,
    output logic [ADDR_W-1:0] dir_adr,
    input  logic              dir_valid,
    input  logic              dir_dirty,
    output logic              wb_req,
    input  logic              wb_ack,
    output logic              dir_wr,
    output logic              dir_wr_valid,
    output logic              dir_wr_dirty,
    output logic              SWEEP_BUSY,
    output logic              SWEEP_DONE
);

    // Geometry sanity: power-of-two sets/ways and a non-empty page field.
    if (PAGE_W < 1 || NSETS < 2 || (NSETS & (NSETS - 1)) != 0 ||
        NWAYS < 1 || (NWAYS & (NWAYS - 1)) != 0) begin : g_bad_cfg
        $error("cca_sweep_ctl: NSETS/NWAYS must be powers of two and PAGE_W >= 1");
    end

    sweep_state_e state_d;
    sweep_state_e state_q;
    sweep_func_e  func_d;
    sweep_func_e  func_q;

    logic              ctr_clr;
    logic              ctr_inc;
    logic              ctr_last;
    logic [ADDR_W-1:0] ctr_cnt;

    logic entry_sel;
    logic need_wb;
    logic need_wr;

`ifdef CCA_PAGE_SWEEP_EN
    logic              page_sweep_d;
    logic              page_sweep_q;
    logic [PAGE_W-1:0] page_sel_d;
    logic [PAGE_W-1:0] page_sel_q;

    // A page-restricted sweep treats any entry from another page as if it were invalid.
    assign entry_sel = ~page_sweep_q | (dir_page == page_sel_q);
`else
    assign entry_sel = 1'b1;
`endif

    // Writeback only for dirty lines, and never when the contents are being discarded.
    assign need_wb = entry_sel & dir_valid & dir_dirty & (func_q != FUNC_CLEAR);
    // Rewrite when the entry is invalidated (CLEAR/UNLOAD) or has a dirty bit to clear.
    assign need_wr = entry_sel & dir_valid & ((func_q != FUNC_VALIDATE) | dir_dirty);

    cca_sweep_ctr #(
        .NENT   (NSETS * NWAYS),
        .ADDR_W (ADDR_W)
    ) u_ctr (
        .clk     (clk),
        .RESET_N (RESET_N),
        .clr     (ctr_clr),
        .inc     (ctr_inc),
        .cnt     (ctr_cnt),
        .last    (ctr_last)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!RESET_N) begin
            state_q      <= ST_IDLE;
            func_q       <= FUNC_CLEAR;
`ifdef CCA_PAGE_SWEEP_EN
            page_sweep_q <= 1'b0;
            page_sel_q   <= '0;
`endif
        end else begin
            state_q      <= state_d;
            func_q       <= func_d;
`ifdef CCA_PAGE_SWEEP_EN
            page_sweep_q <= page_sweep_d;
            page_sel_q   <= page_sel_d;
`endif
        end
    end

    // Next-state logic; also owns the counter controls and the request latches.
    always_comb begin
        state_d      = state_q;
        func_d       = func_q;
        ctr_clr      = 1'b0;
        ctr_inc      = 1'b0;
`ifdef CCA_PAGE_SWEEP_EN
        page_sweep_d = page_sweep_q;
        page_sel_d   = page_sel_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    func_d       = decode_func(func);
                    ctr_clr      = 1'b1;
`ifdef CCA_PAGE_SWEEP_EN
                    page_sweep_d = page_sweep;
                    page_sel_d   = page_sel;
`endif
                    state_d      = ST_RD;
                end
            end
            ST_RD: begin
                if (!ebox_hold) begin
                    state_d = ST_CHK;
                end
            end
            ST_CHK: begin
                if (need_wb) begin
                    state_d = ST_WB;
                end else if (need_wr) begin
                    state_d = ST_WR;
                end else if (ctr_last) begin
                    state_d = ST_DONE;
                end else begin
                    ctr_inc = 1'b1;
                    state_d = ST_RD;
                end
            end
            ST_WB: begin
                if (wb_ack) begin
                    state_d = ST_WR;
                end
            end
            ST_WR: begin
                if (ctr_last) begin
                    state_d = ST_DONE;
                end else begin
                    ctr_inc = 1'b1;
                    state_d = ST_RD;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output decode. Everything is forced low while RESET_N is asserted so an abort
    // takes effect in the same cycle rather than one edge later.
    always_comb begin
        dir_rd       = 1'b0;
        wb_req       = 1'b0;
        dir_wr       = 1'b0;
        dir_wr_valid = 1'b0;
        dir_wr_dirty = 1'b0;
        SWEEP_BUSY   = 1'b0;
        SWEEP_DONE   = 1'b0;
        if (RESET_N) begin
            case (state_q)
                ST_RD: begin
                    dir_rd     = ~ebox_hold;
                    SWEEP_BUSY = 1'b1;
                end
                ST_CHK: begin
                    SWEEP_BUSY = 1'b1;
                end
                ST_WB: begin
                    wb_req     = 1'b1;
                    SWEEP_BUSY = 1'b1;
                end
                ST_WR: begin
                    dir_wr       = 1'b1;
                    dir_wr_valid = (func_q == FUNC_VALIDATE);
                    SWEEP_BUSY   = 1'b1;
                end
                ST_DONE: begin
                    SWEEP_DONE = 1'b1;
                end
                default: begin
                    SWEEP_BUSY = 1'b0;
                end
            endcase
        end
    end

    assign dir_adr = RESET_N ? ctr_cnt : '0;

endmodule

// File: tb/tb_cca_sweep_ctl.sv
module tb_cca_sweep_ctl;

    localparam int NS = 2;
    localparam int NW = 2;
    localparam int NE = NS * NW;
    localparam int AW = 2;
    localparam int PW = 13;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          RESET_N;
    logic          start;
    logic [1:0]    func;
    logic          ebox_hold;
    logic          dir_rd;
    logic [AW-1:0] dir_adr;
    logic          dir_valid;
    logic          dir_dirty;
    logic          wb_req;
    logic          wb_ack;
    logic          dir_wr;
    logic          dir_wr_valid;
    logic          dir_wr_dirty;
    logic          SWEEP_BUSY;
    logic          SWEEP_DONE;
`ifdef CCA_PAGE_SWEEP_EN
    logic          page_sweep;
    logic [PW-1:0] page_sel;
    logic [PW-1:0] dir_page;
`endif

    cca_sweep_ctl #(
        .NSETS  (NS),
        .NWAYS  (NW),
        .PAGE_W (PW)
    ) dut (
        .clk          (clk),
        .RESET_N      (RESET_N),
        .start        (start),
        .func         (func),
`ifdef CCA_PAGE_SWEEP_EN
        .page_sweep   (page_sweep),
        .page_sel     (page_sel),
        .dir_page     (dir_page),
`endif
        .ebox_hold    (ebox_hold),
        .dir_rd       (dir_rd),
        .dir_adr      (dir_adr),
        .dir_valid    (dir_valid),
        .dir_dirty    (dir_dirty),
        .wb_req       (wb_req),
        .wb_ack       (wb_ack),
        .dir_wr       (dir_wr),
        .dir_wr_valid (dir_wr_valid),
        .dir_wr_dirty (dir_wr_dirty),
        .SWEEP_BUSY   (SWEEP_BUSY),
        .SWEEP_DONE   (SWEEP_DONE)
    );

    int checks   = 0;
    int failures = 0;

    // Directory contents seen by the DUT.
    bit          mem_v [NE];
    bit          mem_d [NE];
    logic [PW-1:0] mem_p [NE];

    int cyc      = 0;
    int wb_delay = 0;
    int sweep_c0 = 0;

    // Observed activity since the last start_sweep.
    int done_cyc [$];
    int wr_adr   [$];
    int wr_v     [$];
    int wr_d     [$];
    int wb_adr   [$];
    int rd_adr   [$];
    int wb_cycles;
    int wb_adr_err;
    int busy_cycles;

    // Expected results from the reference model.
    int exp_wr_adr [$];
    int exp_wr_v   [$];
    int exp_wb_adr [$];
    int exp_cycles;
    bit exp_mem_v [NE];
    bit exp_mem_d [NE];

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Directory / writeback responder and activity monitor, all on the falling edge.
    initial begin : responder
        bit rd_pend;
        int rd_a;
        int wb_n;
        int wb_a;
        bit wb_prev;
        rd_pend = 0; rd_a = 0; wb_n = 0; wb_a = 0; wb_prev = 0;
        dir_valid = 1'b0;
        dir_dirty = 1'b0;
        wb_ack    = 1'b0;
`ifdef CCA_PAGE_SWEEP_EN
        dir_page  = '0;
`endif
        forever begin
            @(negedge clk);
            cyc++;
            // Read data is returned the cycle after the read strobe.
            if (rd_pend) begin
                dir_valid = mem_v[rd_a];
                dir_dirty = mem_d[rd_a];
`ifdef CCA_PAGE_SWEEP_EN
                dir_page  = mem_p[rd_a];
`endif
            end else begin
                dir_valid = 1'b0;
                dir_dirty = 1'b0;
            end
            rd_pend = dir_rd;
            rd_a    = int'(dir_adr);
            if (dir_rd) rd_adr.push_back(int'(dir_adr));
            if (wb_req) begin
                if (!wb_prev) begin
                    wb_adr.push_back(int'(dir_adr));
                    wb_a = int'(dir_adr);
                    wb_n = 0;
                end else if (int'(dir_adr) != wb_a) begin
                    wb_adr_err++;
                end
                wb_n++;
                wb_cycles++;
                wb_ack = (wb_n == wb_delay + 1);
            end else begin
                wb_ack = 1'b0;
            end
            wb_prev = wb_req;
            if (dir_wr) begin
                wr_adr.push_back(int'(dir_adr));
                wr_v.push_back(int'(dir_wr_valid));
                wr_d.push_back(int'(dir_wr_dirty));
                mem_v[dir_adr] = dir_wr_valid;
                mem_d[dir_adr] = dir_wr_dirty;
            end
            if (SWEEP_DONE) done_cyc.push_back(cyc);
            if (SWEEP_BUSY) busy_cycles++;
        end
    end

    // Reference model: walk entries in order, applying the sweep rules to a copy of the directory.
    task automatic build_model(input int f, input bit psweep, input int psel);
        int eff;
        bit sel, v, d, do_wb, do_wr;
        eff = (f == 3) ? 1 : f;
        exp_wr_adr.delete();
        exp_wr_v.delete();
        exp_wb_adr.delete();
        exp_cycles = 1;
        for (int e = 0; e < NE; e++) begin
            sel   = !psweep || (int'(mem_p[e]) == psel);
            v     = mem_v[e];
            d     = mem_d[e];
            do_wb = sel && v && d && (eff != 0);
            do_wr = sel && v && ((eff != 1) || d);
            exp_mem_v[e] = v;
            exp_mem_d[e] = d;
            if (do_wb) begin
                exp_wb_adr.push_back(e);
                exp_cycles += wb_delay + 1;
            end
            if (do_wr) begin
                exp_wr_adr.push_back(e);
                exp_wr_v.push_back((eff == 1) ? 1 : 0);
                exp_mem_v[e] = (eff == 1);
                exp_mem_d[e] = 1'b0;
                exp_cycles += 3;
            end else begin
                exp_cycles += 2;
            end
        end
    endtask

    task automatic start_sweep(input int f, input bit psweep, input int psel);
        build_model(f, psweep, psel);
        done_cyc.delete(); wr_adr.delete(); wr_v.delete(); wr_d.delete();
        wb_adr.delete(); rd_adr.delete();
        wb_cycles = 0; wb_adr_err = 0; busy_cycles = 0;
        @(posedge clk); #1;
        start = 1'b1;
        func  = f[1:0];
`ifdef CCA_PAGE_SWEEP_EN
        page_sweep = psweep;
        page_sel   = PW'(psel);
`endif
        sweep_c0 = cyc + 1;
        @(posedge clk); #1;
        start = 1'b0;
        func  = 2'($urandom);
`ifdef CCA_PAGE_SWEEP_EN
        page_sweep = 1'($urandom);
        page_sel   = PW'($urandom);
`endif
    endtask

    task automatic finish_sweep(input string tag, input int extra);
        int n, lat, mo, me;
        n = 0;
        while (done_cyc.size() == 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        repeat (4) @(posedge clk);
        #1;
        check({tag, ".done_cnt"}, done_cyc.size(), 1);
        lat = (done_cyc.size() > 0) ? done_cyc[0] - sweep_c0 : -1;
        check({tag, ".latency"}, lat, exp_cycles + extra);
        check({tag, ".busy_cycles"}, busy_cycles, exp_cycles + extra - 1);
        check({tag, ".wr_cnt"}, wr_adr.size(), exp_wr_adr.size());
        for (int i = 0; i < wr_adr.size() && i < exp_wr_adr.size(); i++) begin
            check($sformatf("%s.wr%0d_adr", tag, i), wr_adr[i], exp_wr_adr[i]);
            check($sformatf("%s.wr%0d_valid", tag, i), wr_v[i], exp_wr_v[i]);
            check($sformatf("%s.wr%0d_dirty", tag, i), wr_d[i], 0);
        end
        check({tag, ".wb_cnt"}, wb_adr.size(), exp_wb_adr.size());
        for (int i = 0; i < wb_adr.size() && i < exp_wb_adr.size(); i++)
            check($sformatf("%s.wb%0d_adr", tag, i), wb_adr[i], exp_wb_adr[i]);
        check({tag, ".wb_cycles"}, wb_cycles, exp_wb_adr.size() * (wb_delay + 1));
        check({tag, ".wb_adr_stable"}, wb_adr_err, 0);
        mo = 0; me = 0;
        for (int e = 0; e < NE; e++) begin
            mo[2*e] = mem_v[e]; mo[2*e+1] = mem_d[e];
            me[2*e] = exp_mem_v[e]; me[2*e+1] = exp_mem_d[e];
        end
        check({tag, ".dir_after"}, mo, me);
        check({tag, ".busy_idle"}, int'(SWEEP_BUSY), 0);
    endtask

    task automatic fill_mem(input bit v, input bit d);
        for (int e = 0; e < NE; e++) begin
            mem_v[e] = v;
            mem_d[e] = d;
            mem_p[e] = '0;
        end
    endtask

    initial begin : stim
        int n;
        RESET_N   = 1'b0;
        start     = 1'b0;
        func      = 2'b00;
        ebox_hold = 1'b0;
`ifdef CCA_PAGE_SWEEP_EN
        page_sweep = 1'b0;
        page_sel   = '0;
`endif
        fill_mem(0, 0);

        // Reset values.
        repeat (3) @(negedge clk);
        #1;
        check("rst.dir_rd", int'(dir_rd), 0);
        check("rst.dir_adr", int'(dir_adr), 0);
        check("rst.wb_req", int'(wb_req), 0);
        check("rst.dir_wr", int'(dir_wr), 0);
        check("rst.dir_wr_valid", int'(dir_wr_valid), 0);
        check("rst.dir_wr_dirty", int'(dir_wr_dirty), 0);
        check("rst.busy", int'(SWEEP_BUSY), 0);
        check("rst.done", int'(SWEEP_DONE), 0);
        @(posedge clk); #1;
        RESET_N = 1'b1;
        rd_adr.delete(); busy_cycles = 0;
        repeat (10) @(posedge clk);
        #1;
        check("idle.no_rd", rd_adr.size(), 0);
        check("idle.busy_cycles", busy_cycles, 0);

        // CLEAR sweep, everything valid and dirty: no writebacks, 13-cycle completion.
        fill_mem(1, 1);
        wb_delay = 0;
        start_sweep(0, 0, 0);
        finish_sweep("clear", 0);
        check("clear.lat13", (done_cyc.size() > 0) ? done_cyc[0] - sweep_c0 : -1, 13);
        check("clear.no_wb", wb_adr.size(), 0);

        // UNLOAD sweep with a slow writeback on entry 1.
        fill_mem(0, 0);
        mem_v[1] = 1; mem_d[1] = 1;
        mem_v[2] = 1; mem_d[2] = 0;
        wb_delay = 5;
        start_sweep(2, 0, 0);
        finish_sweep("unload", 0);
        check("unload.wb_len", wb_cycles, 6);
        check("unload.wb_adr", (wb_adr.size() > 0) ? wb_adr[0] : -1, 1);
        check("unload.wr_cnt2", wr_adr.size(), 2);

        // Pause during RD, ignored mid-sweep start, ignored start in the DONE cycle.
        fill_mem(1, 1);
        wb_delay = 0;
        start_sweep(0, 0, 0);
        n = 0;
        while (rd_adr.size() < 2 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        ebox_hold = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        start = 1'b1;
        func  = 2'b10;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("hold.rd_frozen", rd_adr.size(), 2);
        check("hold.wr_not_blocked", wr_adr.size(), 2);
        ebox_hold = 1'b0;
        @(posedge clk); #1;
        check("hold.resume_adr", (rd_adr.size() > 2) ? rd_adr[2] : -1, 2);
        n = 0;
        while (cyc < sweep_c0 + 20 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        start = 1'b1;
        func  = 2'b01;
        @(posedge clk); #1;
        start = 1'b0;
        finish_sweep("hold", 8);
        check("hold.no_restart_rd", rd_adr.size(), 4);

        // Abort with reset during a pending writeback.
        fill_mem(0, 0);
        mem_v[1] = 1; mem_d[1] = 1;
        wb_delay = 30;
        start_sweep(2, 0, 0);
        n = 0;
        while (wb_adr.size() == 0 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("abort.wb_seen", wb_adr.size(), 1);
        RESET_N = 1'b0;
        @(negedge clk); #1;
        check("abort.wb_req", int'(wb_req), 0);
        check("abort.busy", int'(SWEEP_BUSY), 0);
        @(posedge clk); #1;
        RESET_N = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check("abort.no_done", done_cyc.size(), 0);
        check("abort.no_wr", wr_adr.size(), 0);
        check("abort.busy_after", int'(SWEEP_BUSY), 0);
        wb_delay = 1;
        start_sweep(0, 0, 0);
        finish_sweep("after_abort", 0);
        check("after_abort.first_rd", (rd_adr.size() > 0) ? rd_adr[0] : -1, 0);

`ifdef CCA_PAGE_SWEEP_EN
        // Page-restricted VALIDATE: only entry 2 belongs to page 0x12.
        fill_mem(1, 1);
        for (int e = 0; e < NE; e++) mem_p[e] = PW'(16'h0100 + e);
        mem_p[2] = PW'(16'h0012);
        wb_delay = 2;
        start_sweep(1, 1, 'h12);
        finish_sweep("page", 0);
        check("page.wb_cnt1", wb_adr.size(), 1);
        check("page.wr_cnt1", wr_adr.size(), 1);
        check("page.wr_valid", (wr_v.size() > 0) ? wr_v[0] : -1, 1);
`endif

        // Randomized sweeps against the reference model.
        for (int k = 0; k < 8; k++) begin
            for (int e = 0; e < NE; e++) begin
                mem_v[e] = 1'($urandom);
                mem_d[e] = 1'($urandom);
                mem_p[e] = '0;
            end
            wb_delay = $urandom_range(0, 3);
            start_sweep($urandom_range(0, 3), 0, 0);
            finish_sweep($sformatf("rand%0d", k), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
